// File: rtl/fp_issue_controller.sv
// fp_issue_controller: issues one FP instruction at a time to the FPU over its
// start/done level protocol and returns the result (or an error) to writeback.
module fp_issue_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [4:0]  req_rd_i,
    output logic        fpu_start_o,
    output logic [1:0]  fpu_operation_o,
    output logic [31:0] fpu_op_a_o,
    output logic [31:0] fpu_op_b_o,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_result_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o,
    output logic        timeout_seen_o
);

    localparam logic [31:0] QNaN    = 32'h7FC0_0000;
    localparam logic [7:0]  CntLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWb,
        StReject
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
    logic        timeout_hit;

    // >= rather than == so that an ISSUE->WAIT handoff on the last allowed
    // cycle still times out on the following cycle instead of running on.
    assign timeout_hit = (cnt_q >= CntLast);

    // Next-state logic: sequencing, counter, operand and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        data_d    = data_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    rd_d    = req_rd_i;
                    cnt_d   = 8'd0;
                    state_d = req_op_i[1] ? StReject : StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + 8'd1;
                // done high here only means the FPU has not started yet
                if (!fpu_done_i) begin
                    state_d = StWait;
                end else if (timeout_hit) begin
                    data_d    = QNaN;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StWb;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (fpu_done_i) begin
                    data_d  = fpu_result_i;
                    err_d   = 1'b0;
                    state_d = StWb;
                end else if (timeout_hit) begin
                    data_d    = QNaN;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StWb;
                end
            end
            StReject: begin
                data_d  = QNaN;
                err_d   = 1'b1;
                state_d = StWb;
            end
            StWb: begin
                if (wb_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and held-register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rd_q      <= 5'd0;
            data_q    <= 32'd0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore outputs decoded from state and held registers.
    always_comb begin
        req_ready_o     = (state_q == StIdle);
        fpu_start_o     = (state_q == StIssue);
        wb_valid_o      = (state_q == StWb);
        fpu_operation_o = op_q;
        fpu_op_a_o      = a_q;
        fpu_op_b_o      = b_q;
        wb_rd_o         = rd_q;
        wb_data_o       = data_q;
        wb_err_o        = err_q;
        timeout_seen_o  = timeout_q;
    end

endmodule

// File: tb/tb_fp_issue_controller.sv
// Testbench for fp_issue_controller: each transaction's timeline is derived from
// the FPU done schedule the bench drives, and every cycle is compared.
module tb_fp_issue_controller;

    localparam int unsigned T    = 16;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        fpu_start;
    logic [1:0]  fpu_operation;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err, timeout_seen;

    always #5 clk = ~clk;

    fp_issue_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_rd_i       (req_rd),
        .fpu_start_o    (fpu_start),
        .fpu_operation_o(fpu_operation),
        .fpu_op_a_o     (fpu_op_a),
        .fpu_op_b_o     (fpu_op_b),
        .fpu_done_i     (fpu_done),
        .fpu_result_i   (fpu_result),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .wb_err_o       (wb_err),
        .timeout_seen_o (timeout_seen)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // expectations for the current cycle
    logic        chk_en = 1'b0, chk_wb = 1'b0, chk_fpu = 1'b0;
    logic        exp_ready, exp_start, exp_wbv, exp_err;
    logic        tos_model = 1'b0;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data, exp_a, exp_b;
    logic [1:0]  exp_op;

    // per-transaction observations of the DUT
    int          seen_start, seen_wb;
    logic [31:0] seen_data;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // single compare process against the model's per-cycle expectations
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("fpu_start", 32'(fpu_start), 32'(exp_start));
            check("wb_valid", 32'(wb_valid), 32'(exp_wbv));
            check("timeout_seen", 32'(timeout_seen), 32'(tos_model));
            if (chk_wb) begin
                check("wb_rd", 32'(wb_rd), 32'(exp_rd));
                check("wb_data", wb_data, exp_data);
                check("wb_err", 32'(wb_err), 32'(exp_err));
            end
            if (chk_fpu) begin
                check("fpu_operation", 32'(fpu_operation), 32'(exp_op));
                check("fpu_op_a", fpu_op_a, exp_a);
                check("fpu_op_b", fpu_op_b, exp_b);
            end
        end
    end

    task automatic cycle_end(input int k, input int wbs);
        @(negedge clk);
        if (fpu_start === 1'b1) seen_start++;
        if (wb_valid === 1'b1 && seen_wb < 0) seen_wb = k;
        if (k == wbs) seen_data = wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        req_op     = 2'($urandom);
        req_a      = $urandom;
        req_b      = $urandom;
        req_rd     = 5'($urandom);
        fpu_result = $urandom;
    endtask

    task automatic exp_idle();
        chk_en = 1'b1; chk_wb = 1'b0; chk_fpu = 1'b0;
        exp_ready = 1'b1; exp_start = 1'b0; exp_wbv = 1'b0;
    endtask

    task automatic exp_reset();
        chk_en = 1'b1; chk_wb = 1'b1; chk_fpu = 1'b1;
        exp_ready = 1'b1; exp_start = 1'b0; exp_wbv = 1'b0;
        exp_rd = 5'd0; exp_data = 32'd0; exp_err = 1'b0;
        exp_op = 2'd0; exp_a = 32'd0; exp_b = 32'd0;
        tos_model = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            junk_inputs();
            fpu_done = 1'($urandom);
            wb_ready = 1'($urandom);
            exp_idle();
            cycle_end(-1, -2);
        end
    endtask

    // One transaction. The FPU keeps done high for h cycles after acceptance,
    // low for the next l cycles, then high again with the result.
    // rst_at > 0 applies reset during that busy cycle instead of completing.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int h, input int l,
                           input logic [31:0] res, input int stall, input int rst_at);
        int          c, tb_end, wbs;
        logic        legal, tmo;
        logic [31:0] data;
        logic        err;
        legal = !op[1];
        c      = h + l + 1;                              // cycle sampling done back high
        tb_end = (h + 1 == int'(T)) ? int'(T) + 1 : int'(T); // last cycle before timeout
        tmo    = 1'b0;
        if (!legal) begin
            wbs = 2; data = QNAN; err = 1'b1;
        end else if (c <= tb_end) begin
            wbs = c + 1; data = res; err = 1'b0;
        end else begin
            wbs = tb_end + 1; data = QNAN; err = 1'b1; tmo = 1'b1;
        end
        seen_start = 0; seen_wb = -1; seen_data = 32'd0;

        // acceptance cycle
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        fpu_done = 1'b1; fpu_result = $urandom; wb_ready = 1'($urandom);
        exp_idle();
        cycle_end(0, wbs);

        for (int k = 1; k < wbs; k++) begin
            req_valid = 1'($urandom);
            junk_inputs();
            wb_ready = 1'($urandom);
            if (legal) begin
                fpu_done = (k <= h) ? 1'b1 : (k <= h + l) ? 1'b0 : 1'b1;
                fpu_result = (k == c) ? res : $urandom;
            end else begin
                fpu_done = 1'($urandom);
            end
            chk_en = 1'b1; chk_wb = 1'b0; chk_fpu = 1'b1;
            exp_ready = 1'b0; exp_wbv = 1'b0;
            exp_start = legal && (k <= h + 1);
            exp_op = op; exp_a = a; exp_b = b;
            reset = (k == rst_at);
            cycle_end(k, wbs);
            if (k == rst_at) begin
                reset = 1'b0;
                req_valid = 1'b0;
                exp_reset();
                cycle_end(k + 1, -2);
                return;
            end
        end

        if (tmo) tos_model = 1'b1;
        for (int s = 0; s <= stall; s++) begin
            req_valid = 1'($urandom);
            junk_inputs();
            fpu_done = 1'($urandom);
            wb_ready = (s == stall);
            chk_en = 1'b1; chk_wb = 1'b1; chk_fpu = 1'b1;
            exp_ready = 1'b0; exp_start = 1'b0; exp_wbv = 1'b1;
            exp_rd = rd; exp_data = data; exp_err = err;
            exp_op = op; exp_a = a; exp_b = b;
            cycle_end(wbs + s, wbs);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'($urandom); wb_ready = 1'($urandom);
        fpu_done = 1'($urandom);
        junk_inputs();
        cycle_end(-1, -2);
        junk_inputs();
        exp_reset();
        cycle_end(-1, -2);
        reset = 1'b0;
        idle_cycles(2);

        // legal add: start high 2 cycles, result 13 cycles after acceptance
        run_txn(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1, 10, 32'h4040_0000, 0, -1);
        check("add_start_cycles", 32'(seen_start), 32'd2);
        check("add_wb_cycle", 32'(seen_wb), 32'd13);
        check("add_wb_data", seen_data, 32'h4040_0000);
        idle_cycles(1);

        // illegal opcode
        run_txn(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0, 1, 32'h0, 1, -1);
        check("illegal_start_cycles", 32'(seen_start), 32'd0);
        check("illegal_wb_cycle", 32'(seen_wb), 32'd2);
        check("illegal_wb_data", seen_data, QNAN);
        idle_cycles(1);

        // FPU never leaves idle: 16 ISSUE cycles then error writeback
        run_txn(2'b01, 32'h3F80_0000, 32'h3F80_0000, 5'd9, 1000, 1, 32'h0, 2, -1);
        check("timeout_start_cycles", 32'(seen_start), 32'd16);
        check("timeout_wb_cycle", 32'(seen_wb), 32'd17);
        check("timeout_wb_data", seen_data, QNAN);
        idle_cycles(2);
        check("timeout_sticky", 32'(timeout_seen), 32'd1);

        // multiply with 5 cycles of writeback backpressure
        run_txn(2'b01, 32'h4000_0000, 32'h4040_0000, 5'd21, 2, 3, 32'h40C0_0000, 5, -1);
        check("mul_wb_cycle", 32'(seen_wb), 32'd7);
        check("mul_wb_data", seen_data, 32'h40C0_0000);
        idle_cycles(1);

        // reset during WAIT aborts with no writeback, next request is normal
        run_txn(2'b00, 32'h3F80_0000, 32'h3F80_0000, 5'd4, 1, 10, 32'h4000_0000, 0, 5);
        check("rst_mid_no_wb", 32'(seen_wb), 32'hFFFF_FFFF);
        idle_cycles(1);
        run_txn(2'b00, 32'h3F80_0000, 32'h3F80_0000, 5'd5, 0, 2, 32'h4000_0000, 1, -1);
        check("post_rst_wb_data", seen_data, 32'h4000_0000);
        idle_cycles(1);

        // randomized transactions
        for (int i = 0; i < 80; i++) begin
            run_txn(2'($urandom), $urandom, $urandom, 5'($urandom),
                    int'($urandom_range(0, 20)), int'($urandom_range(1, 12)), $urandom,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0) ? 1 : -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
